// File: rtl/des_iter_ctrl.sv
// Sequencer for the iterative single-round DES datapath: block handshake,
// 16-round schedule with key-shift commands, final permutation and result hold.
module des_iter_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             key_wr,
    input  logic             cfg_decrypt,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dp_load_blk,
    output logic             dp_key_restore,
    output logic             dp_round_en,
    output logic [1:0]       dp_key_shift,
    output logic             dp_key_dir,
    output logic             dp_final,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             key_loaded,
    output logic             key_wr_err,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t state;
    logic   mode;
    logic   accept;
    logic   in_flight;

    assign in_flight = (state == ROUND) || (state == FINAL);

    // abort wins over a simultaneous accept, so it masks in_ready directly
    assign in_ready = key_loaded && !abort &&
                      ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    assign dp_load_blk    = accept;
    assign dp_key_restore = accept;
    assign dp_round_en    = (state == ROUND);
    assign dp_final       = (state == FINAL);
    assign out_valid      = (state == DONE);
    assign busy           = (state != IDLE);
    assign dp_key_dir     = (state == ROUND) && mode;

    // Decrypt skips the round-0 shift: the restored master key already equals
    // the round-16 encrypt schedule, and the rest mirrors the encrypt table.
    always_comb begin
        dp_key_shift = 2'd0;
        if (state == ROUND) begin
            case (round_idx)
                4'd0:                dp_key_shift = mode ? 2'd0 : 2'd1;
                4'd1, 4'd8, 4'd15:   dp_key_shift = 2'd1;
                default:             dp_key_shift = 2'd2;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            round_idx  <= 4'd0;
            mode       <= 1'b0;
            key_loaded <= 1'b0;
            key_wr_err <= 1'b0;
            blk_count  <= '0;
        end else begin
            key_wr_err <= key_wr && in_flight;
            if (key_wr && !in_flight)
                key_loaded <= 1'b1;

            if (abort) begin
                state     <= IDLE;
                round_idx <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state     <= ROUND;
                            round_idx <= 4'd0;
                            mode      <= cfg_decrypt;
                        end
                    end
                    ROUND: begin
                        if (round_idx == LAST_ROUND) begin
                            state     <= FINAL;
                            round_idx <= 4'd0;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                    FINAL: state <= DONE;
                    DONE: begin
                        if (out_ready) begin
                            blk_count <= blk_count + CNT_W'(1);
                            if (accept) begin
                                state     <= ROUND;
                                round_idx <= 4'd0;
                                mode      <= cfg_decrypt;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl: key gating, encrypt/decrypt schedules,
// back-to-back throughput, abort, busy key writes, result hold and async reset.
module tb_des_iter_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN, key_wr, cfg_decrypt, abort, in_valid, out_ready;
    logic        in_ready, out_valid, dp_load_blk, dp_key_restore, dp_round_en;
    logic [1:0]  dp_key_shift;
    logic        dp_key_dir, dp_final, busy, key_loaded, key_wr_err;
    logic [3:0]  round_idx;
    logic [31:0] blk_count;

    int total = 0;
    int bad   = 0;

    int enc_tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_tbl [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_iter_ctrl #(.NUM_ROUNDS(16), .CNT_W(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .key_wr(key_wr), .cfg_decrypt(cfg_decrypt),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .dp_load_blk(dp_load_blk), .dp_key_restore(dp_key_restore),
        .dp_round_en(dp_round_en), .dp_key_shift(dp_key_shift), .dp_key_dir(dp_key_dir),
        .dp_final(dp_final), .round_idx(round_idx), .busy(busy), .key_loaded(key_loaded),
        .key_wr_err(key_wr_err), .blk_count(blk_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // One full block from IDLE; optional key_wr at round kw_at, hold cycles in DONE.
    task automatic run_block(input bit dec, input int kw_at, input int hold,
                             input logic [31:0] exp_cnt);
        cfg_decrypt = dec;
        in_valid    = 1'b1;
        #1;
        chk("accept_in_ready", in_ready, 1);
        chk("accept_load", dp_load_blk, 1);
        chk("accept_restore", dp_key_restore, 1);
        tick();
        in_valid    = 1'b0;
        cfg_decrypt = ~dec;
        for (int r = 0; r < 16; r++) begin
            #1;
            chk("round_en", dp_round_en, 1);
            chk("round_idx", round_idx, r);
            chk("key_shift", dp_key_shift, dec ? dec_tbl[r] : enc_tbl[r]);
            chk("key_dir", dp_key_dir, dec);
            chk("round_out_valid", out_valid, 0);
            chk("round_in_ready", in_ready, 0);
            if (r == kw_at) key_wr = 1'b1;
            tick();
            key_wr = 1'b0;
            chk("key_wr_err", key_wr_err, (r == kw_at) ? 1 : 0);
        end
        #1;
        chk("final", dp_final, 1);
        chk("final_round_en", dp_round_en, 0);
        chk("final_shift", dp_key_shift, 0);
        chk("final_dir", dp_key_dir, 0);
        chk("final_out_valid", out_valid, 0);
        tick();
        chk("done_out_valid", out_valid, 1);
        chk("done_final", dp_final, 0);
        chk("done_key_wr_err", key_wr_err, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("consume_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b0;
        chk("consumed_out_valid", out_valid, 0);
        chk("consumed_busy", busy, 0);
        chk("blk_count", blk_count, exp_cnt);
    endtask

    initial begin
        int n;
        int acc_cyc [3];
        bit ov_seen;

        ARESETN = 1'b0; key_wr = 1'b0; cfg_decrypt = 1'b0; abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_key_loaded", key_loaded, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_round_en", dp_round_en, 0);
        chk("rst_round_idx", round_idx, 0);
        ARESETN = 1'b1;

        // No key yet: block must not be accepted
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_busy", busy, 0);
        end
        in_valid = 1'b0;
        key_wr   = 1'b1;
        tick();
        key_wr = 1'b0;
        chk("key_loaded", key_loaded, 1);
        chk("key_idle_err", key_wr_err, 0);
        chk("key_in_ready", in_ready, 1);

        run_block(1'b0, -1, 0, 32'd1);
        run_block(1'b1, -1, 0, 32'd2);

        // Back-to-back with in_valid and out_ready tied high
        n = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            #1;
            if (dp_load_blk && n < 3) begin
                acc_cyc[n] = c;
                n++;
            end
            tick();
            if (n == 3) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("b2b_accepts", n, 3);
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 18);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 18);
        chk("b2b_count", blk_count, 32'd5);
        chk("b2b_idle", busy, 0);

        // Abort beats a simultaneous accept
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort_prio_ready", in_ready, 0);
        chk("abort_prio_load", dp_load_blk, 0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_prio_busy", busy, 0);

        // Abort at round 7
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort_at_idx", round_idx, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_round_en", dp_round_en, 0);
        chk("abort_round_idx", round_idx, 0);
        ov_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) ov_seen = 1'b1;
        end
        chk("abort_no_out_valid", ov_seen, 0);
        chk("abort_count", blk_count, 32'd5);
        chk("abort_key_loaded", key_loaded, 1);
        run_block(1'b0, -1, 0, 32'd6);

        // key_wr during ROUND, then a 10-cycle hold in DONE
        run_block(1'b0, 4, 10, 32'd7);
        chk("kw_key_loaded", key_loaded, 1);

        // Async reset mid-block
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_round_en", dp_round_en, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_key_loaded", key_loaded, 0);
        chk("mid_rst_count", blk_count, 0);
        tick();
        ARESETN = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
